// File: rtl/keypoint_reader_if.sv
// Bundles the keypoint reader's control inputs, BRAM read port and keypoint output stream.
// master = the reader itself; slave = the environment (BRAM, sequencer and consumer).
interface keypoint_reader_if #(
    parameter int DIMENSION = 4,
    parameter int KEY_DEPTH = DIMENSION * DIMENSION
);
    localparam int W  = $clog2(DIMENSION);
    localparam int AW = $clog2(KEY_DEPTH);
    localparam int CW = AW + 1;

    logic          start;
    logic [CW-1:0] keypt_count;
    logic [AW-1:0] key_read_addr;
    logic [2*W:0]  key_data;
    logic [W-1:0]  kp_x;
    logic [W-1:0]  kp_y;
    logic          kp_level;
    logic          kp_valid;
    logic          kp_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] emitted_count;

    modport master (
        input  start, keypt_count, key_data, kp_ready,
        output key_read_addr, kp_x, kp_y, kp_level, kp_valid, busy, done, emitted_count
    );

    modport slave (
        output start, keypt_count, key_data, kp_ready,
        input  key_read_addr, kp_x, kp_y, kp_level, kp_valid, busy, done, emitted_count
    );
endinterface

// File: rtl/keypoint_reader.sv
// Drains the keypoint BRAM into a 4-entry credit-controlled FIFO and streams (x, y, level).
// Optional KEYPOINT_READER_BORDER_FILTER_EN drops keypoints lying on the image border.
module keypoint_reader #(
    parameter int DIMENSION    = 4,
    parameter int KEY_DEPTH    = DIMENSION * DIMENSION,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_in,
    keypoint_reader_if.master   bus
);
    localparam int W          = $clog2(DIMENSION);
    localparam int AW         = $clog2(KEY_DEPTH);
    localparam int CW         = AW + 1;
    localparam int FIFO_DEPTH = 4;
    localparam int PW         = 2;
    localparam int IW         = $clog2(READ_LATENCY + FIFO_DEPTH + 2) + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_emitted;
    logic [AW-1:0]         r_addr;
    logic                  r_addr_vld;
    logic [READ_LATENCY-1:0] r_lat;
    logic [READ_LATENCY:0] w_pipe_in;
    logic [2*W:0]          r_fifo [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW:0]           r_occ;

    logic [CW-1:0]         w_count_clamped;
    logic [IW-1:0]         w_inflight;
    logic                  w_start;
    logic                  w_issue;
    logic                  w_credit;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_keep;
    logic                  w_busy;
    logic                  w_done;
    logic [2*W:0]          w_head;

    assign w_count_clamped = (bus.keypt_count > CW'(KEY_DEPTH)) ? CW'(KEY_DEPTH) : bus.keypt_count;

    // Valid pipe: the address-register stage followed by READ_LATENCY BRAM stages.
    assign w_pipe_in[0] = r_addr_vld;
    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
            assign w_pipe_in[gi+1] = r_lat[gi];
        end
    endgenerate

    always_comb begin
        w_inflight = IW'(r_addr_vld);
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + IW'(r_lat[i]);
        end
    end

`ifdef KEYPOINT_READER_BORDER_FILTER_EN
    logic [W-1:0] w_in_x;
    logic [W-1:0] w_in_y;
    assign w_in_x = bus.key_data[2*W:W+1];
    assign w_in_y = bus.key_data[W:1];
    assign w_keep = !((w_in_x == '0) || (w_in_x == W'(DIMENSION - 1)) ||
                      (w_in_y == '0) || (w_in_y == W'(DIMENSION - 1)));
`else
    assign w_keep = 1'b1;
`endif

    assign w_head   = r_fifo[r_rd_ptr];
    assign w_pop    = bus.kp_valid & bus.kp_ready;
    assign w_push   = r_lat[READ_LATENCY-1] & w_keep;
    assign w_start  = (r_state == IDLE) & bus.start;
    // A slot freed by this cycle's pop may be re-credited at once, so a full pipe still streams.
    assign w_credit = ((IW'(r_occ) + w_inflight - IW'(w_pop)) < IW'(FIFO_DEPTH));
    // The first read goes out on the start edge itself so its address appears the next cycle.
    assign w_issue  = (w_start & (w_count_clamped != '0)) |
                      ((r_state == READ) & (r_issued < r_count) & w_credit);

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_state_next = READ;
            end
            READ: begin
                // A zero count spends one cycle here so done lands two cycles after start.
                if (r_count == '0)
                    w_state_next = FINISH;
                else if ((r_issued == r_count) || (w_issue && ((r_issued + 1'b1) == r_count)))
                    w_state_next = DRAIN;
            end
            DRAIN: begin
                if ((w_inflight == '0) && ((r_occ == '0) || ((r_occ == 1) && w_pop)))
                    w_state_next = FINISH;
            end
            FINISH: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_issued   <= '0;
            r_emitted  <= '0;
            r_addr     <= '0;
            r_addr_vld <= 1'b0;
            r_lat      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            r_state    <= w_state_next;
            r_addr_vld <= w_issue;
            r_lat      <= w_pipe_in[READ_LATENCY-1:0];

            if (w_start) begin
                r_count   <= w_count_clamped;
                r_issued  <= w_issue ? CW'(1) : '0;
                r_emitted <= '0;
            end else begin
                if (w_issue) r_issued  <= r_issued + 1'b1;
                if (w_pop)   r_emitted <= r_emitted + 1'b1;
            end

            if (w_issue) r_addr <= w_start ? '0 : r_issued[AW-1:0];

            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.key_data;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_occ <= r_occ + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    assign bus.key_read_addr = r_addr;
    assign bus.kp_x          = w_head[2*W:W+1];
    assign bus.kp_y          = w_head[W:1];
    assign bus.kp_level      = w_head[0];
    assign bus.kp_valid      = (r_occ != '0);
    assign bus.busy          = w_busy;
    assign bus.done          = w_done;
    assign bus.emitted_count = r_emitted;
endmodule

// File: tb/tb_keypoint_reader.sv
// Directed bench for keypoint_reader with a 2-cycle BRAM model and a transfer monitor.
// Relative cycle 0 is the cycle in which start is held high.
module tb_keypoint_reader;
    localparam int DIM = 4;
    localparam int KD  = 16;

    typedef struct {
        int x;
        int y;
        int l;
        int rel;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_in;
    always #5 clk = ~clk;

    keypoint_reader_if #(.DIMENSION(DIM), .KEY_DEPTH(KD)) bus ();

    keypoint_reader #(.DIMENSION(DIM), .KEY_DEPTH(KD), .READ_LATENCY(2)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    logic [4:0] mem [KD];
    logic [4:0] bram_r1;
    always @(posedge clk) begin
        bram_r1      <= mem[bus.key_read_addr];
        bus.key_data <= bram_r1;
    end

    xfer_t got_q[$];
    xfer_t exp_q[$];
    int    done_q[$];
    int    addr_q[$];
    int    last_addr;
    bit    logging = 1'b0;
    int    cyc = 0;
    int    s_cyc = 0;
    int    rdy_mode = 0;
    int    max_out = 0;
    int    n_total = 0;
    int    n_bad = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin : rdy_drv
        int rel;
        #1;
        rel = cyc - s_cyc;
        case (rdy_mode)
            1:       bus.kp_ready = (rel >= 4 && rel <= 12) ? 1'b0 : 1'b1;
            2:       bus.kp_ready = ((rel % 2) == 0);
            default: bus.kp_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin : mon
        int rel;
        xfer_t t;
        rel = cyc - s_cyc;
        if (logging) begin
            if (rel >= 1 && int'(bus.key_read_addr) != last_addr) begin
                addr_q.push_back(int'(bus.key_read_addr));
                last_addr = int'(bus.key_read_addr);
            end
            if (addr_q.size() - got_q.size() > max_out) max_out = addr_q.size() - got_q.size();
            if (bus.kp_valid && bus.kp_ready) begin
                t.x = int'(bus.kp_x); t.y = int'(bus.kp_y); t.l = int'(bus.kp_level); t.rel = rel;
                got_q.push_back(t);
            end
            if (bus.done) done_q.push_back(rel);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit keep(input int x, input int y);
`ifdef KEYPOINT_READER_BORDER_FILTER_EN
        return !(x == 0 || x == DIM - 1 || y == 0 || y == DIM - 1);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int got_rel(input int i);
        return (i < got_q.size()) ? got_q[i].rel : -1;
    endfunction

    function automatic int first_done();
        return (done_q.size() > 0) ? done_q[0] : -1;
    endfunction

    task automatic run_pass(input int n, input int mode);
        int eff;
        logic [4:0] v;
        xfer_t e;
        @(posedge clk); #1;
        got_q.delete(); done_q.delete(); addr_q.delete(); exp_q.delete();
        last_addr = -1; max_out = 0;
        rdy_mode = mode; s_cyc = cyc; logging = 1'b1;
        bus.start = 1'b1; bus.keypt_count = 5'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 300 && done_q.size() == 0; i++) @(posedge clk);
        repeat (3) @(negedge clk);
        logging = 1'b0;
        check("done_pulses", done_q.size(), 1);
        eff = (n > KD) ? KD : n;
        for (int i = 0; i < eff; i++) begin
            v = mem[i];
            e.x = int'(v[4:3]); e.y = int'(v[2:1]); e.l = int'(v[0]); e.rel = 0;
            if (keep(e.x, e.y)) exp_q.push_back(e);
        end
        check("xfer_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            $display("xfer %0d: x=%0d y=%0d level=%0d cycle=%0d", i, got_q[i].x, got_q[i].y,
                     got_q[i].l, got_q[i].rel);
            check("xfer_x", got_q[i].x, exp_q[i].x);
            check("xfer_y", got_q[i].y, exp_q[i].y);
            check("xfer_level", got_q[i].l, exp_q[i].l);
        end
        check("emitted_count", int'(bus.emitted_count), exp_q.size());
        check("busy_after", int'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_in = 1'b1; bus.start = 1'b0; bus.keypt_count = '0;
        for (int i = 0; i < KD; i++) mem[i] = 5'((i * 13 + 5) % 32);
        repeat (3) @(posedge clk); #1;
        rst_in = 1'b0;
        @(negedge clk);
        check("rst_addr", int'(bus.key_read_addr), 0);
        check("rst_valid", int'(bus.kp_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_emitted", int'(bus.emitted_count), 0);
        check("rst_kp", int'({bus.kp_x, bus.kp_y, bus.kp_level}), 0);

        // Zero count: no output, done two cycles after start.
        run_pass(0, 0);
        check("zero_done_cycle", first_done(), 2);

        // Three entries, consumer always ready.
        mem[0] = 5'b10_01_1; mem[1] = 5'b01_10_0; mem[2] = 5'b11_11_1;
        run_pass(3, 0);
`ifndef KEYPOINT_READER_BORDER_FILTER_EN
        check("t1_first_x", (got_q.size() > 0) ? got_q[0].x : -1, 2);
        check("t1_last_y", (got_q.size() > 2) ? got_q[2].y : -1, 3);
        check("t1_cycle0", got_rel(0), 4);
        check("t1_cycle1", got_rel(1), 5);
        check("t1_cycle2", got_rel(2), 6);
        check("t1_done_cycle", first_done(), 7);
`endif

        // Same data, consumer stalled for cycles 4..12.
        run_pass(3, 1);
        check("stall_max_out", int'(max_out <= 4), 1);
`ifndef KEYPOINT_READER_BORDER_FILTER_EN
        check("stall_first_cycle", got_rel(0), 13);
        check("stall_done_cycle", first_done(), 16);
`endif

        // Sixteen entries, ready toggling every cycle.
        for (int i = 0; i < KD; i++) mem[i] = 5'((i * 13 + 5) % 32);
        run_pass(16, 2);
        check("toggle_addr_count", addr_q.size(), 16);
        for (int i = 0; i < addr_q.size(); i++) check("toggle_addr_seq", addr_q[i], i);
`ifndef KEYPOINT_READER_BORDER_FILTER_EN
        check("toggle_max_out", int'(max_out <= 4), 1);
`endif

        // Count above depth is clamped to KD.
        run_pass(31, 0);
        check("clamp_addr_count", addr_q.size(), KD);

        // Reset during a 16-entry pass, then restart with count 2.
        @(posedge clk); #1;
        got_q.delete(); done_q.delete(); addr_q.delete(); last_addr = -1;
        rdy_mode = 0; s_cyc = cyc; logging = 1'b1;
        bus.start = 1'b1; bus.keypt_count = 5'd16;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk); #1;
        rst_in = 1'b1;
        @(negedge clk);
        check("abort_rst_valid", int'(bus.kp_valid), 0);
        check("abort_rst_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        rst_in = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_done", done_q.size(), 0);
        check("abort_valid_after", int'(bus.kp_valid), 0);
        check("abort_emitted", int'(bus.emitted_count), 0);
        logging = 1'b0;
        run_pass(2, 0);

`ifdef KEYPOINT_READER_BORDER_FILTER_EN
        // Border filter: (0,2,1) is dropped.
        mem[0] = 5'b01_01_0; mem[1] = 5'b00_10_1; mem[2] = 5'b10_10_1;
        run_pass(3, 0);
        check("filt_count", got_q.size(), 2);
        check("filt_x1", (got_q.size() > 1) ? got_q[1].x : -1, 2);
        check("filt_l1", (got_q.size() > 1) ? got_q[1].l : -1, 1);
        check("filt_emitted", int'(bus.emitted_count), 2);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
